mux_scan_sequencer: RTL

//  Drives the select lines of the 4:1 multiplexer and samples its output, one

---
 rtl/mux_scan_if.sv | 23 ++
 rtl/mux_scan_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/mux_scan_if.sv
// Handshake and mux-control bundle between the scan sequencer (master) and
// the mux/downstream side (slave).
interface mux_scan_if;
    logic       start;
    logic       continuous;
    logic       mux_out;
    logic       address0;
    logic       address1;
    logic [3:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       busy;

    modport master (
        input  start, continuous, mux_out, sample_ready,
        output address0, address1, sample_data, sample_valid, busy
    );

    modport slave (
        output start, continuous, mux_out, sample_ready,
        input  address0, address1, sample_data, sample_valid, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux channel by channel with settle time, packs the four samples
// into a word and delivers it downstream on a valid/ready handshake.
//
// state   | meaning
// IDLE    | address parked at 0, waiting for start
// SETTLE  | address held, counting settle cycles
// SAMPLE  | capture mux_out into sample_data[addr], advance channel
// DELIVER | word presented, waiting for sample_ready
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic        clk,
    input logic        reset,
    mux_scan_if.master bus
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_SAMPLE  = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_addr;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_data;
    logic            r_valid;
    logic            r_busy;

    assign bus.address0     = r_addr[0];
    assign bus.address1     = r_addr[1];
    assign bus.sample_data  = r_data;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= 2'd0;
            r_cnt   <= '0;
            r_data  <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= 2'd0;
                    if (bus.start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    r_data[r_addr] <= bus.mux_out;
                    if (r_addr == 2'd3) begin
                        r_state <= S_DELIVER;
                        r_valid <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 2'd1;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                S_DELIVER: begin
                    // Word and address stay frozen until accepted; this is the backpressure stall.
                    if (bus.sample_ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= 2'd0;
                        r_cnt   <= '0;
                        if (bus.continuous) begin
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_addr  <= 2'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
